// File: rtl/alu_stream_sequencer.sv
// Stream front-end for the ALU BFM: buffers {B, A, op} command beats, issues each
// one with a start pulse, waits for done (or a timeout) and streams the result out.
module alu_stream_sequencer #(
  parameter int ITEM_WIDTH     = 8,
  parameter int OP_WIDTH       = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int BATCH_LEN      = 100,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic [2*ITEM_WIDTH+OP_WIDTH-1:0] s_tdata,
  output logic                             start,
  output logic [OP_WIDTH-1:0]              op_s,
  output logic [ITEM_WIDTH-1:0]            A_s,
  output logic [ITEM_WIDTH-1:0]            B_s,
  input  logic                             done,
  input  logic [2*ITEM_WIDTH-1:0]          res_i,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [2*ITEM_WIDTH-1:0]          m_tdata,
  output logic                             m_tlast,
  output logic                             m_terr,
  output logic                             xmit_en,
  output logic                             err_timeout,
  output logic [15:0]                      items_done
);

  localparam int DW = 2*ITEM_WIDTH + OP_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BATCH_LAST = BW'(BATCH_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [DW-1:0] head;
  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [BW-1:0] batch_cnt;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_tready = reset_i && !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = (state == S_IDLE) && !empty;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign m_tlast  = m_tvalid && (batch_cnt == BATCH_LAST);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      start       <= 1'b0;
      op_s        <= '0;
      A_s         <= '0;
      B_s         <= '0;
      wait_cnt    <= '0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_terr      <= 1'b0;
      err_timeout <= 1'b0;
      items_done  <= '0;
      batch_cnt   <= '0;
      xmit_en     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          rd_ptr <= rd_ptr + (AW+1)'(1);
          op_s   <= head[OP_WIDTH-1:0];
          A_s    <= head[OP_WIDTH +: ITEM_WIDTH];
          B_s    <= head[OP_WIDTH+ITEM_WIDTH +: ITEM_WIDTH];
          start  <= 1'b1;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          start    <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout landing on the same edge
          if (done) begin
            m_tdata  <= res_i;
            m_terr   <= 1'b0;
            m_tvalid <= 1'b1;
            state    <= S_OUT;
          end else if (wait_cnt == WAIT_LAST) begin
            m_tdata     <= '1;
            m_terr      <= 1'b1;
            err_timeout <= 1'b1;
            m_tvalid    <= 1'b1;
            state       <= S_OUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_OUT: if (m_tready) begin
          m_tvalid   <= 1'b0;
          items_done <= items_done + 16'd1;
          if (batch_cnt == BATCH_LAST) begin
            batch_cnt <= '0;
            xmit_en   <= ~xmit_en;
          end else begin
            batch_cnt <= batch_cnt + BW'(1);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stream_sequencer.sv
// Scoreboard bench for alu_stream_sequencer: directed commands push expected results,
// a monitor pops and compares on every accepted output beat.
module tb_alu_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [18:0] s_tdata = '0;
  logic        start;
  logic [2:0]  op_s;
  logic [7:0]  A_s, B_s;
  logic        done;
  logic        alu_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [15:0] res_i = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [15:0] m_tdata;
  logic        m_tlast, m_terr, xmit_en, err_timeout;
  logic [15:0] items_done;

  assign done = alu_done | stray_done;

  alu_stream_sequencer dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .start(start), .op_s(op_s), .A_s(A_s), .B_s(B_s),
    .done(done), .res_i(res_i),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_terr(m_terr),
    .xmit_en(xmit_en), .err_timeout(err_timeout), .items_done(items_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   alu_delay = 1;
  int   start_cnt = 0;
  int   push_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a} * {8'h00, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // ALU model: answers each start after alu_delay cycles (0 = never answers)
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (reset_i && start) begin
        start_cnt++;
        d = alu_delay;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          res_i    = alu_f(op_s, A_s, B_s);
          alu_done = 1'b1;
          @(posedge clk);
          #1;
          alu_done = 1'b0;
        end
      end
    end
  end

  // Monitor: output stability while stalled, and in-order result check on acceptance
  initial begin
    exp_t        x;
    logic        held;
    logic [15:0] hd;
    logic        he, hl;
    held = 1'b0; hd = '0; he = 1'b0; hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_i) held = 1'b0;
      else begin
        if (held && m_tvalid) begin
          chk("hold_data", m_tdata, hd);
          chk("hold_err", m_terr, he);
          chk("hold_last", m_tlast, hl);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h, required no result", m_tdata);
          end else begin
            x = exp_q.pop_front();
            chk("res_data", m_tdata, x.d);
            chk("res_err", m_terr, x.e);
            chk("res_last", m_tlast, x.l);
          end
        end
        held = m_tvalid && !m_tready;
        hd = m_tdata; he = m_terr; hl = m_tlast;
      end
    end
  end

  // Called right after a posedge (+#1); returns aligned the same way.
  task automatic push(input logic [7:0] b, input logic [7:0] a, input logic [2:0] op,
                      input logic [15:0] ed, input logic ee);
    exp_t x;
    int   g;
    x.d = ed;
    x.e = ee;
    x.l = ((push_idx % 100) == 99);
    push_idx++;
    exp_q.push_back(x);
    s_tdata  = {b, a, op};
    s_tvalid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!s_tready && g < 3000);
    if (!s_tready) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: got s_tready=0, required 1 within 3000 cycles");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  va [6] = '{8'd4,   8'd16,    8'd255,   8'd200,   8'hF0,    8'd1};
  logic [7:0]  vb [6] = '{8'd3,   8'd16,    8'd255,   8'd100,   8'h0F,    8'd2};
  logic [2:0]  vo [6] = '{3'd2,   3'd2,     3'd2,     3'd1,     3'd0,     3'd1};
  logic [15:0] vr [6] = '{16'h000c, 16'h0100, 16'hfe01, 16'h012c, 16'h00ff, 16'h0003};

  initial begin
    int s0;
    int i0;
    #1 reset_i = 1'b0;
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_start", start, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_xmit_en", xmit_en, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_items_done", items_done, 0);
    chk("rst_op_a_b", {op_s, A_s, B_s}, 0);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1;

    // single command: 5 + 3
    push(8'h03, 8'h05, 3'd1, 16'h0008, 1'b0);
    drain();
    chk("t1_start_pulses", start_cnt, 1);
    chk("t1_op_s", op_s, 1);
    chk("t1_A_s", A_s, 5);
    chk("t1_B_s", B_s, 3);
    chk("t1_items_done", items_done, 1);

    // backpressure: six beats with the output stalled
    m_tready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) push(vb[i], va[i], vo[i], vr[i], 1'b0);
      begin
        repeat (30) @(posedge clk);
        #1;
        chk("bp_s_tready_low", s_tready, 0);
        chk("bp_m_tvalid", m_tvalid, 1);
        chk("bp_m_tdata", m_tdata, 16'h000c);
        m_tready = 1'b1;
      end
    join
    drain();
    chk("bp_items_done", items_done, 7);

    // complete the first batch of 100 results
    for (int i = 7; i < 100; i++) push(8'd1, 8'(i), 3'd1, 16'(i + 1), 1'b0);
    drain();
    chk("batch1_xmit_en", xmit_en, 1);
    chk("batch1_items_done", items_done, 100);
    for (int i = 0; i < 100; i++) push(8'd1, 8'(i), 3'd1, 16'(i + 1), 1'b0);
    drain();
    chk("batch2_xmit_en", xmit_en, 0);
    chk("batch2_items_done", items_done, 200);

    // stray done while idle
    s0 = start_cnt;
    stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stray_idle_m_tvalid", m_tvalid, 0);
    chk("stray_idle_starts", start_cnt, s0);
    chk("stray_idle_items", items_done, 200);

    // stray done while a result is held
    m_tready = 1'b0;
    push(8'd7, 8'd9, 3'd2, 16'h003f, 1'b0);
    repeat (10) @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_out_m_tvalid", m_tvalid, 1);
    chk("stray_out_m_tdata", m_tdata, 16'h003f);
    m_tready = 1'b1;
    drain();

    // timeout, then a normal command keeps err_timeout sticky
    alu_delay = 0;
    push(8'd2, 8'd2, 3'd1, 16'hffff, 1'b1);
    drain();
    chk("to_err_timeout", err_timeout, 1);
    alu_delay = 1;
    push(8'd2, 8'd2, 3'd1, 16'h0004, 1'b0);
    drain();
    chk("to_sticky", err_timeout, 1);

    // done on the final wait cycle wins; one cycle later is a timeout
    alu_delay = 64;
    push(8'h10, 8'h20, 3'd0, 16'h0030, 1'b0);
    drain();
    alu_delay = 65;
    push(8'h10, 8'h20, 3'd0, 16'hffff, 1'b1);
    drain();
    chk("late_items_done", items_done, 205);

    // reset while waiting with two beats buffered
    alu_delay = 0;
    push(8'd1, 8'd1, 3'd1, 16'h0002, 1'b0);
    push(8'd2, 8'd2, 3'd1, 16'h0004, 1'b0);
    push(8'd3, 8'd3, 3'd1, 16'h0006, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
    chk("mrst_m_tvalid", m_tvalid, 0);
    chk("mrst_s_tready", s_tready, 0);
    chk("mrst_err_timeout", err_timeout, 0);
    chk("mrst_items_done", items_done, 0);
    chk("mrst_xmit_en", xmit_en, 0);
    exp_q.delete();
    push_idx = 0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    s0 = start_cnt;
    @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_late_done_m_tvalid", m_tvalid, 0);
    chk("mrst_fifo_empty_no_start", start_cnt, s0);
    chk("mrst_s_tready_up", s_tready, 1);
    alu_delay = 1;
    push(8'h11, 8'h22, 3'd1, 16'h0033, 1'b0);
    drain();
    i0 = 1;
    chk("post_rst_items_done", items_done, i0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
